// File: rtl/fifo_rd_prefetch.sv
// Read-prefetching FIFO controller around an external dual-port RAM with a
// one-cycle registered read port; a 2-entry head/skid buffer hides that latency.
module fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH+1:0] level
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [1:0] occ_after_pop;
  logic [1:0] cnt_shift;

  // RAM holds D words exactly when the count MSB is set.
  assign s_ready = rst_n & ~ram_count_q[ADDR_WIDTH];
  assign m_valid = (buf_count_q != 2'd0);
  assign m_data  = head_q;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // Buffer + in-flight never exceeds 2, so this cannot overflow 2 bits.
  assign occ_after_pop = buf_count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_issue      = (ram_count_q != '0) && (occ_after_pop < 2'd2);

  assign ram_we    = push;
  assign ram_waddr = wr_ptr_q;
  assign ram_wdata = push ? s_data : '0;
  assign ram_raddr = rd_ptr_q;

  assign level = {1'b0, ram_count_q}
               + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
               + {{ADDR_WIDTH{1'b0}}, buf_count_q};

  always_comb begin
    wr_ptr_d    = push     ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = rd_issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    ram_count_d = ram_count_q + {{ADDR_WIDTH{1'b0}}, push}
                              - {{ADDR_WIDTH{1'b0}}, rd_issue};
    inflight_d  = rd_issue;

    head_d      = head_q;
    skid_d      = skid_q;
    cnt_shift   = buf_count_q;
    buf_count_d = buf_count_q;

    // Pop shifts skid to head first; an arriving word then fills the first free slot.
    if (pop) begin
      head_d    = skid_q;
      cnt_shift = buf_count_q - 2'd1;
    end
    if (inflight_q) begin
      if (cnt_shift == 2'd0) head_d = ram_rdata;
      else                   skid_d = ram_rdata;
      buf_count_d = cnt_shift + 2'd1;
    end else begin
      buf_count_d = cnt_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: RAM model plus a queue-based FIFO reference,
// directed latency/fill/drain/stream checks, random backpressure and mid-stream reset.
module tb_fifo_rd_prefetch;
  localparam int DW = 2;
  localparam int AW = 5;
  localparam int D  = 2**AW;
  localparam int CAP = D + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW+1:0] level;

  fifo_rd_prefetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .level(level)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read; contents are never cleared.
  logic [DW-1:0] mem [D];
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < D; i++) mem[i] = DW'($urandom);
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words accepted and not yet popped, in arrival order.
  logic [DW-1:0] q[$];

  logic          obs_push, obs_pop, obs_have, obs_we, obs_mvalid;
  logic [DW-1:0] obs_data, obs_exp, obs_wdata;
  int            obs_level;

  task automatic drive_cycle();
    @(negedge clk);
    obs_push   = s_valid && s_ready;
    obs_pop    = m_valid && m_ready;
    obs_mvalid = m_valid;
    obs_data   = m_data;
    obs_we     = ram_we;
    obs_wdata  = ram_wdata;
    obs_have   = (q.size() > 0);
    obs_exp    = obs_have ? q[0] : '0;
    @(posedge clk);
    #1;
    if (obs_push) q.push_back(s_data);
    if (obs_pop && obs_have) void'(q.pop_front());
    obs_level = int'(level);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 2'd3; m_ready = 1'b1;
    #2;
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || level !== '0 || ram_we !== 1'b0 ||
        m_data !== '0 || ram_waddr !== '0 || ram_raddr !== '0 || ram_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got s_ready=%b m_valid=%b level=%0d we=%b m_data=%0h waddr=%0d raddr=%0d wdata=%0h expected all 0",
               s_ready, m_valid, level, ram_we, m_data, ram_waddr, ram_raddr, ram_wdata);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got s_ready=%b m_valid=%b level=%0d expected 1 0 0", s_ready, m_valid, level);
    end
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 2'h2; m_ready = 1'b1;
    drive_cycle();
    n_cmp++;
    if (obs_we !== 1'b1 || obs_wdata !== 2'h2) begin
      n_bad++;
      $display("FAIL single_write: got we=%b wdata=%0h expected 1 2", obs_we, obs_wdata);
    end
    s_valid = 1'b0; s_data = 2'h1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat_n: got m_valid=%b expected 0", m_valid); end
    drive_cycle();
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat_n1: got m_valid=%b expected 0", m_valid); end
    drive_cycle();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 2'h2) begin
      n_bad++;
      $display("FAIL single_lat_n2: got m_valid=%b m_data=%0h expected 1 2", m_valid, m_data);
    end
    drive_cycle();
    n_cmp++;
    if (!obs_pop || obs_data !== 2'h2 || level !== '0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pop: got pop=%b data=%0h level=%0d m_valid=%b expected 1 2 0 0",
               obs_pop, obs_data, level, m_valid);
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < CAP + 6; i++) begin
      s_data = DW'(i % 4);
      drive_cycle();
      if (obs_push) acc++;
    end
    n_cmp++;
    if (acc != CAP || obs_level != CAP) begin
      n_bad++;
      $display("FAIL fill_count: got accepted=%0d level=%0d expected %0d %0d", acc, obs_level, CAP, CAP);
    end
    n_cmp++;
    if (s_ready !== 1'b0 || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full: got s_ready=%b ram_we=%b expected 0 0", s_ready, ram_we);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_drain();
    int pops = 0;
    m_ready = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < CAP + 6; i++) begin
      drive_cycle();
      if (obs_pop) begin
        pops++;
        n_cmp++;
        if (!obs_have || obs_data !== obs_exp) begin
          n_bad++;
          $display("FAIL drain_data: got %0h expected %0h (pop %0d)", obs_data, obs_exp, pops);
        end
      end
      if (i < CAP && !obs_pop) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_bubble: got no pop at cycle %0d expected pop", i);
      end
    end
    n_cmp++;
    if (pops != CAP || m_valid !== 1'b0 || level !== '0) begin
      n_bad++;
      $display("FAIL drain_end: got pops=%0d m_valid=%b level=%0d expected %0d 0 0", pops, m_valid, level, CAP);
    end
  endtask

  task automatic test_stream();
    int pops = 0;
    int first = -1;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = DW'(i);
      drive_cycle();
      if (obs_pop) begin
        pops++;
        if (first < 0) first = i;
        n_cmp++;
        if (!obs_have || obs_data !== obs_exp) begin
          n_bad++;
          $display("FAIL stream_data: got %0h expected %0h at cycle %0d", obs_data, obs_exp, i);
        end
      end else if (first >= 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_bubble: got no pop at cycle %0d expected pop", i);
      end
    end
    n_cmp++;
    if (first != 3 || pops != 97) begin
      n_bad++;
      $display("FAIL stream_rate: got first=%0d pops=%0d expected 3 97", first, pops);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle();
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_data !== obs_exp) begin
          n_bad++;
          $display("FAIL stream_tail: got %0h expected %0h", obs_data, obs_exp);
        end
      end
    end
    n_cmp++;
    if (level !== '0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_empty: got level=%0d model=%0d expected 0 0", level, q.size());
    end
  endtask

  task automatic test_random_backpressure();
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      drive_cycle();
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_data !== obs_exp) begin
          n_bad++;
          $display("FAIL rand_data: got %0h expected %0h at cycle %0d", obs_data, obs_exp, i);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (obs_data !== prev_data) begin
          n_bad++;
          $display("FAIL rand_stable: got %0h expected %0h at cycle %0d", obs_data, prev_data, i);
        end
      end
      n_cmp++;
      if (obs_level != q.size() || obs_level > CAP) begin
        n_bad++;
        $display("FAIL rand_level: got %0d expected %0d (max %0d) at cycle %0d", obs_level, q.size(), CAP, i);
      end
      prev_stall = obs_mvalid && !obs_pop;
      prev_data  = obs_data;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < CAP + 6; i++) begin
      drive_cycle();
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_data !== obs_exp) begin
          n_bad++;
          $display("FAIL rand_drain: got %0h expected %0h", obs_data, obs_exp);
        end
      end
    end
    n_cmp++;
    if (level !== '0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_empty: got level=%0d model=%0d expected 0 0", level, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] w;
    int seen = 0;
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_data = DW'($urandom);
      drive_cycle();
    end
    m_ready = 1'b1; s_data = DW'($urandom);
    drive_cycle();
    n_cmp++;
    if (obs_level != 10) begin
      n_bad++;
      $display("FAIL midrst_level: got %0d expected 10", obs_level);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || level !== '0 || ram_we !== 1'b0 ||
        m_data !== '0 || ram_waddr !== '0 || ram_raddr !== '0 || ram_wdata !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got s_ready=%b m_valid=%b level=%0d we=%b m_data=%0h waddr=%0d raddr=%0d expected all 0",
               s_ready, m_valid, level, ram_we, m_data, ram_waddr, ram_raddr);
    end
    q.delete();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_release: got s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      s_data = DW'($urandom);
      drive_cycle();
      n_cmp++;
      if (obs_mvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_idle: got m_valid=%b expected 0 at cycle %0d", obs_mvalid, i);
      end
    end
    w = DW'($urandom);
    s_valid = 1'b1; s_data = w;
    drive_cycle();
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle();
      if (obs_pop) begin
        seen++;
        n_cmp++;
        if (obs_data !== w || i != 2) begin
          n_bad++;
          $display("FAIL midrst_first: got %0h at cycle %0d expected %0h at cycle 2", obs_data, i, w);
        end
      end
    end
    n_cmp++;
    if (seen != 1) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d pops expected 1", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_random_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
